// File: rtl/result_bcd_display.sv
// Binary (0..63) to two-digit BCD converter using serial double-dabble,
// driving a multiplexed two-digit active-low seven-segment display.
module result_bcd_display #(
    parameter int REFRESH_CYCLES = 1000,
    parameter bit BLANK_LEADING  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] result,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       done,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int CW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_CYCLES - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    state_t        state_q;
    logic [5:0]    shift_q;
    logic [11:0]   bcd_q;
    logic [2:0]    iter_q;
    logic [3:0]    tens_q;
    logic [3:0]    ones_q;
    logic          done_q;
    logic [CW-1:0] ref_q;
    logic          sel_q;
    logic [6:0]    seg_q;
    logic [1:0]    an_q;

    logic [11:0]   bcd_adj;
    logic [17:0]   dd_d;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // One double-dabble step: correct each nibble, then shift {bcd,shift} left.
    always_comb begin
        bcd_adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
        dd_d    = {bcd_adj, shift_q} << 1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        shift_q <= result;
                        bcd_q   <= '0;
                        iter_q  <= '0;
                        state_q <= CONVERT;
                    end
                end
                CONVERT: begin
                    shift_q <= dd_d[5:0];
                    bcd_q   <= dd_d[17:6];
                    iter_q  <= iter_q + 3'd1;
                    if (iter_q == 3'd5) begin
                        tens_q  <= dd_d[13:10];
                        ones_q  <= dd_d[9:6];
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Display multiplexer runs freely; conversions never touch it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ref_q <= '0;
            sel_q <= 1'b0;
            seg_q <= 7'b1000000;
            an_q  <= 2'b10;
        end else begin
            if (ref_q == REF_LAST) begin
                ref_q <= '0;
                sel_q <= ~sel_q;
            end else begin
                ref_q <= ref_q + 1'b1;
            end
            if (sel_q) begin
                seg_q <= enc(tens_q);
                an_q  <= (BLANK_LEADING && tens_q == 4'd0) ? 2'b11 : 2'b01;
            end else begin
                seg_q <= enc(ones_q);
                an_q  <= 2'b10;
            end
        end
    end

    assign in_ready = (state_q == IDLE);
    assign tens     = tens_q;
    assign ones     = ones_q;
    assign done     = done_q;
    assign seg      = seg_q;
    assign an       = an_q;

endmodule

// File: tb/tb_result_bcd_display.sv
// Directed bench for result_bcd_display: latency, sweep, display mux,
// leading-zero blanking, ignore-while-busy and mid-conversion abort.
module tb_result_bcd_display;

    logic       clk = 1'b0;
    logic       run = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [5:0] result;
    logic       in_ready, in_ready_nb;
    logic [3:0] tens, ones, tens_nb, ones_nb;
    logic       done, done_nb;
    logic [6:0] seg, seg_nb;
    logic [1:0] an, an_nb;

    int checks = 0;
    int passed = 0;

    result_bcd_display #(.REFRESH_CYCLES(4), .BLANK_LEADING(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .result(result), .tens(tens), .ones(ones), .done(done),
        .seg(seg), .an(an)
    );

    result_bcd_display #(.REFRESH_CYCLES(4), .BLANK_LEADING(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_nb),
        .result(result), .tens(tens_nb), .ones(ones_nb), .done(done_nb),
        .seg(seg_nb), .an(an_nb)
    );

    always begin
        #5;
        if (run) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Transfer v, then follow the conversion edge by edge.
    task automatic xfer(input logic [5:0] v, input logic [3:0] et,
                        input logic [3:0] eo, input bit hold, input bit noise);
        chk("ready_pre", in_ready, 1'b1);
        in_valid = 1'b1;
        result   = v;
        tick();
        chk("busy_k", in_ready, 1'b0);
        if (!hold) in_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (noise) begin
                in_valid = i[0];
                result   = 6'd9;
            end
            tick();
            chk("busy", in_ready, 1'b0);
            chk("nodone", done, 1'b0);
        end
        if (!hold) in_valid = 1'b0;
        tick();
        chk("done_k6", done, 1'b1);
        chk("ready_k6", in_ready, 1'b1);
        chk("tens", tens, et);
        chk("ones", ones, eo);
        if (!hold) begin
            tick();
            chk("done_1cyc", done, 1'b0);
        end
    endtask

    const logic [5:0] sw_in[6] = '{6'd0, 6'd3, 6'd15, 6'd30, 6'd45, 6'd63};
    const logic [3:0] sw_t[6]  = '{4'd0, 4'd0, 4'd1, 4'd3, 4'd4, 4'd6};
    const logic [3:0] sw_o[6]  = '{4'd0, 4'd3, 4'd5, 4'd0, 4'd5, 4'd3};

    logic [1:0] an_log[24];
    logic [6:0] seg_log[24];

    initial begin
        in_valid = 1'b0;
        result   = '0;
        reset    = 1'b1;
        #1;
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_tens", tens, 4'd0);
        chk("rst_ones", ones, 4'd0);
        chk("rst_an", an, 2'b10);
        chk("rst_seg", seg, 7'b1000000);
        #3;
        run = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Latency with in_valid held: re-accepted at edge k+7.
        xfer(6'd45, 4'd4, 4'd5, 1'b1, 1'b0);
        tick();
        chk("reaccept_k7", in_ready, 1'b0);
        chk("done_k7", done, 1'b0);
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("reconv_ready", in_ready, 1'b1);
        chk("reconv_tens", tens, 4'd4);
        chk("reconv_ones", ones, 4'd5);
        tick();

        for (int i = 0; i < 6; i++) xfer(sw_in[i], sw_t[i], sw_o[i], 1'b0, 1'b0);

        // Ignore in_valid while busy.
        xfer(6'd30, 4'd3, 4'd0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        chk("hold_tens", tens, 4'd3);
        chk("hold_ones", ones, 4'd0);

        // Display mux with tens=1, ones=5.
        xfer(6'd15, 4'd1, 4'd5, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 24; i++) begin
            an_log[i]  = an;
            seg_log[i] = seg;
            tick();
        end
        begin
            int first;
            logic [1:0] a0, ea;
            first = -1;
            for (int i = 1; i < 6; i++)
                if (first < 0 && an_log[i] != an_log[i-1]) first = i;
            chk("mux_edge_found", 16'(first >= 1), 16'd1);
            if (first < 1) first = 1;
            a0 = an_log[first];
            for (int j = 0; j < 16; j++) begin
                ea = ((j / 4) % 2 == 0) ? a0 : ~a0;
                chk("mux_an", an_log[first+j], ea);
                chk("mux_seg", seg_log[first+j],
                    (ea == 2'b10) ? 7'b0010010 : 7'b1111001);
            end
        end

        // Leading-zero blanking with value 3.
        xfer(6'd3, 4'd0, 4'd3, 1'b0, 1'b0);
        tick();
        begin
            int tslots;
            tslots = 0;
            for (int i = 0; i < 8; i++) begin
                if (an_nb == 2'b01) begin
                    tslots++;
                    chk("blank_an", an, 2'b11);
                    chk("noblank_seg", seg_nb, 7'b1000000);
                end else begin
                    chk("ones_an", an, 2'b10);
                    chk("ones_an_nb", an_nb, 2'b10);
                    chk("ones_seg", seg, 7'b0110000);
                end
                tick();
            end
            chk("tens_slots", 16'(tslots), 16'd4);
        end

        // Abort at edge k+3.
        in_valid = 1'b1;
        result   = 6'd63;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("abort_ready", in_ready, 1'b1);
        chk("abort_done", done, 1'b0);
        chk("abort_tens", tens, 4'd0);
        chk("abort_ones", ones, 4'd0);
        chk("abort_an", an, 2'b10);
        chk("abort_seg", seg, 7'b1000000);
        tick();
        tick();
        reset = 1'b0;
        begin
            int pulses;
            pulses = 0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (done) pulses++;
            end
            chk("abort_nopulse", 16'(pulses), 16'd0);
        end
        chk("abort_tens_after", tens, 4'd0);

        xfer(6'd15, 4'd1, 4'd5, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
